core_run_ctrl: RTL and testbench

Sequencer for the single-cycle RV32I `DataPath`. It holds the core in reset and streams a program into instruction memory through a valid/ready port. It then releases the core, counts executed cycles, and stops the run when the core reaches the halt idiom `beq x0,x0,0` or when a cycle budget expires. It sits between the system/test host and the `DataPath` instance, owning the core's `reset_n` and the instruction-memory write port.

---
 rtl/core_run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_core_run_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//
// Run sequencer for a single-cycle RV32I DataPath. It keeps the core in reset
// while a program is streamed into instruction memory over a valid/ready port.
// It then releases the core and counts executed cycles. The run ends on the
// halt idiom (beq x0,x0,0) or when the cycle budget is used up. Afterwards the
// core is frozen in reset again, so its register file and data memory can be
// inspected.
//
// Optional feature macro: CORE_RUN_CTRL_HALT_PC_EN
//   When defined, the block has an extra output halt_pc. It holds the core PC
//   of the RUN cycle in which the run ended.
//
// Ports
//   clk, reset       clock (rising edge) and asynchronous active-high reset
//   start            run request, honoured only in IDLE or DONE
//   prog_len         number of words to load (clamped to 2^IMEM_AW)
//   max_cycles       core cycle budget, sampled together with start
//   ld_valid/ld_data program word stream; ld_ready accepts a word
//   imem_we/_waddr/_wdata   instruction-memory write port
//   core_reset_n     drives DataPath.reset_n (high only while running)
//   core_pc          current core PC
//   core_instr       instruction the core is currently fetching
//   busy             high in LOAD or RUN
//   done             one-cycle pulse on entry to DONE
//   halted, timeout  how the last run ended
//   cycle_count      core cycles executed in the current or last run
//   halt_pc          (optional) PC at which the run ended
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int unsigned IMEM_AW   = 6,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] HALT_INSN = 32'h0000_0063
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IMEM_AW:0]   prog_len,
  input  logic [CNT_W-1:0]   max_cycles,
  input  logic               ld_valid,
  input  logic [31:0]        ld_data,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               core_reset_n,
  input  logic [31:0]        core_pc,
  input  logic [31:0]        core_instr,
  output logic               busy,
  output logic               done,
  output logic               halted,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count
`ifdef CORE_RUN_CTRL_HALT_PC_EN
  ,
  output logic [31:0]        halt_pc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [IMEM_AW:0] DEPTH = {1'b1, {IMEM_AW{1'b0}}};

  state_t             state;
  logic [IMEM_AW:0]   len_q;
  logic [IMEM_AW:0]   ld_cnt;
  logic [IMEM_AW:0]   ld_cnt_nxt;
  logic [CNT_W-1:0]   max_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit_halt;
  logic               hit_budget;

  function automatic logic [IMEM_AW:0] clamp_len(input logic [IMEM_AW:0] n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The outputs are decoded straight from the state register. After an
  // asynchronous reset they drop to their idle values at once, and a write
  // that was in flight is cut off in the same cycle.
  assign ld_ready     = (state == S_LOAD);
  assign imem_we      = ld_valid & ld_ready;
  assign imem_waddr   = ld_cnt[IMEM_AW-1:0];
  assign imem_wdata   = ld_data;
  assign core_reset_n = (state == S_RUN);
  assign busy         = (state == S_LOAD) || (state == S_RUN);

  assign ld_cnt_nxt = ld_cnt + (IMEM_AW+1)'(1);

  // cnt_inc is the cycle count that includes the current RUN cycle. The
  // budget expires in the cycle that brings the count up to max_cycles, so a
  // timed-out run reports exactly max_cycles executed cycles. A budget of
  // zero expires on the very first RUN cycle.
  assign cnt_inc    = sat_inc(cycle_count);
  assign hit_halt   = (core_instr == HALT_INSN);
  assign hit_budget = (max_q == '0) || (cnt_inc == max_q);

`ifndef CORE_RUN_CTRL_HALT_PC_EN
  logic unused_core_pc;
  assign unused_core_pc = ^core_pc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      max_q       <= '0;
      ld_cnt      <= '0;
      done        <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
`ifdef CORE_RUN_CTRL_HALT_PC_EN
      halt_pc     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q       <= clamp_len(prog_len);
            max_q       <= max_cycles;
            ld_cnt      <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
`ifdef CORE_RUN_CTRL_HALT_PC_EN
            halt_pc     <= '0;
`endif
            state       <= (prog_len == '0) ? S_RUN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            ld_cnt <= ld_cnt_nxt;
            if (ld_cnt_nxt == len_q) begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cycle_count <= cnt_inc;
          // A halt takes precedence over a budget expiry in the same cycle.
          if (hit_halt) begin
            halted <= 1'b1;
            done   <= 1'b1;
            state  <= S_DONE;
`ifdef CORE_RUN_CTRL_HALT_PC_EN
            halt_pc <= core_pc;
`endif
          end else if (hit_budget) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
`ifdef CORE_RUN_CTRL_HALT_PC_EN
            halt_pc <= core_pc;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_run_ctrl
//
// Bench for core_run_ctrl. A tiny behavioural core is included: its PC steps
// by 4 each cycle and halts on beq x0,x0,0, and it executes addi only. The
// expected result of each run comes from a table of the words the bench has
// loaded, scanned for the first halt inside the budget.
// -----------------------------------------------------------------------------
module tb_core_run_ctrl;

  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam logic [31:0] HALT  = 32'h0000_0063;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   prog_len;
  logic [15:0]   max_cycles;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_reset_n;
  logic [31:0]   core_pc;
  logic [31:0]   core_instr;
  logic          busy;
  logic          done;
  logic          halted;
  logic          timeout;
  logic [15:0]   cycle_count;
`ifdef CORE_RUN_CTRL_HALT_PC_EN
  logic [31:0]   halt_pc;
`endif

  core_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
    .max_cycles(max_cycles), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_reset_n(core_reset_n), .core_pc(core_pc),
    .core_instr(core_instr), .busy(busy), .done(done), .halted(halted),
    .timeout(timeout), .cycle_count(cycle_count)
`ifdef CORE_RUN_CTRL_HALT_PC_EN
    , .halt_pc(halt_pc)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural core plus its instruction memory.
  logic [31:0] cmem [DEPTH];
  logic [31:0] xr [32];
  logic [31:0] pc;
  logic        mem_clr;

  assign core_pc    = pc;
  assign core_instr = cmem[pc[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) cmem[i] <= NOP;
      for (int i = 0; i < 32; i++) xr[i] <= '0;
      pc <= '0;
    end else begin
      if (imem_we) cmem[imem_waddr] <= imem_wdata;
      if (!core_reset_n) begin
        pc <= '0;
      end else begin
        if (core_instr != HALT) pc <= pc + 32'd4;
        if (core_instr[6:0] == 7'h13 && core_instr[14:12] == 3'b000 &&
            core_instr[11:7] != 5'd0)
          xr[core_instr[11:7]] <= xr[core_instr[19:15]] +
                                  {{20{core_instr[31]}}, core_instr[31:20]};
      end
    end
  end

  // Words the bench has handed over; this is what memory should contain.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] prog [128];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_waddr"}, imem_waddr, 0);
    chk({tag, "_core_rstn"}, core_reset_n, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cnt"}, cycle_count, 0);
`ifdef CORE_RUN_CTRL_HALT_PC_EN
    chk({tag, "_halt_pc"}, halt_pc, 0);
`endif
  endtask

  // Outcome of a run over ref_mem: the core walks the words in order, and
  // the budget allows cycles 0..max-1 (only cycle 0 when max is zero).
  task automatic ref_run(input int maxc, output logic exp_h, output int exp_cnt,
                         output int exp_pc);
    int kt;
    kt      = (maxc == 0) ? 0 : maxc - 1;
    exp_h   = 1'b0;
    exp_cnt = kt + 1;
    exp_pc  = 4 * (kt % DEPTH);
    for (int k = 0; k <= kt; k++) begin
      if (ref_mem[k % DEPTH] == HALT) begin
        exp_h   = 1'b1;
        exp_cnt = k + 1;
        exp_pc  = 4 * (k % DEPTH);
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return HALT;
    return {w[31:20], w[19:15], 3'b000, w[11:7], 7'h13};
  endfunction

  // One complete run from IDLE/DONE. mode 0: random ld_valid, 1: ld_valid
  // taken from pat bit per load cycle, 2: ld_valid always high.
  task automatic do_run(input int len, input int maxc, input int mode,
                        input logic [31:0] pat, output int lc);
    int   eff, idx, run_cyc, exp_cnt, exp_pc;
    logic v, exp_h, got_done;
    eff = (len > DEPTH) ? DEPTH : len;
    @(negedge clk);
    start      = 1'b1;
    prog_len   = (AW+1)'(len);
    max_cycles = 16'(maxc);
    idx = 0;
    lc  = 0;
    while (idx < eff && lc < 2000) begin
      @(negedge clk);
      if (mode == 1)      v = (lc < 32) ? pat[lc] : 1'b1;
      else if (mode == 2) v = 1'b1;
      else                v = ($urandom_range(0, 2) != 0);
      ld_valid = v;
      ld_data  = prog[idx];
      start    = ($urandom_range(0, 4) == 0);
      #1;
      chk("load_ready", ld_ready, 1);
      chk("load_rstn", core_reset_n, 0);
      chk("load_busy", busy, 1);
      chk("load_we", imem_we, v);
      chk("load_waddr", imem_waddr, idx);
      chk("load_wdata", imem_wdata, prog[idx]);
      chk("load_cnt", cycle_count, 0);
      chk("load_status", {halted, timeout, done}, 0);
      @(posedge clk);
      if (v) begin
        ref_mem[idx] = prog[idx];
        idx++;
      end
      lc++;
    end
    chk("load_words", idx, eff);
    ref_run(maxc, exp_h, exp_cnt, exp_pc);
    run_cyc  = 0;
    got_done = 1'b0;
    for (int c = 0; c < maxc + 100 && !got_done; c++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
      end else begin
        chk("run_rstn", core_reset_n, 1);
        chk("run_busy", busy, 1);
        chk("run_ready", ld_ready, 0);
        chk("run_we", imem_we, 0);
        chk("run_cnt", cycle_count, run_cyc);
        chk("run_status", {halted, timeout}, 0);
        run_cyc++;
        start = ($urandom_range(0, 3) == 0);
      end
      ld_valid = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("run_cycles", run_cyc, exp_cnt);
    chk("done_halted", halted, exp_h);
    chk("done_timeout", timeout, !exp_h);
    chk("done_cnt", cycle_count, exp_cnt);
    chk("done_rstn", core_reset_n, 0);
    chk("done_busy", busy, 0);
`ifdef CORE_RUN_CTRL_HALT_PC_EN
    chk("done_halt_pc", halt_pc, exp_pc);
`endif
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_halted", halted, exp_h);
    chk("post_timeout", timeout, !exp_h);
    chk("post_cnt", cycle_count, exp_cnt);
    chk("post_rstn", core_reset_n, 0);
  endtask

  int lc;
  int r_len;
  int r_max;

  initial begin
    reset = 1'b1; start = 1'b0; prog_len = '0; max_cycles = '0;
    ld_valid = 1'b0; ld_data = '0; mem_clr = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    for (int i = 0; i < 128; i++) prog[i] = NOP;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    mem_clr = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    // Basic run: two addi then halt.
    prog[0] = 32'h00A0_0093;
    prog[1] = 32'h0050_0113;
    prog[2] = HALT;
    do_run(3, 100, 2, '0, lc);
    chk("basic_load_cyc", lc, 3);
    chk("basic_halted", halted, 1);
    chk("basic_cnt", cycle_count, 3);
    chk("basic_x1", xr[1], 10);
    chk("basic_x2", xr[2], 5);
`ifdef CORE_RUN_CTRL_HALT_PC_EN
    chk("basic_halt_pc", halt_pc, 8);
`endif

    // Halt on the last budgeted cycle: halt wins.
    do_run(3, 3, 2, '0, lc);
    chk("tie_halted", halted, 1);
    chk("tie_timeout", timeout, 0);

    // Budget expiry on a program with no halt.
    for (int i = 0; i < 4; i++) prog[i] = 32'h0011_8193;
    do_run(4, 20, 2, '0, lc);
    chk("bud_timeout", timeout, 1);
    chk("bud_halted", halted, 0);
    chk("bud_cnt", cycle_count, 20);
    chk("bud_rstn", core_reset_n, 0);

    // Reset while a write is in flight.
    @(negedge clk);
    start = 1'b1; prog_len = 7'd5; max_cycles = 16'd50;
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b1; ld_data = NOP;
    #1 chk("rl_we0", imem_we, 1);
    @(posedge clk);
    ref_mem[0] = NOP;
    @(negedge clk);
    ld_data = HALT;
    #1 chk("rl_we1", imem_we, 1);
    #1 reset = 1'b1;
    #1 chk_reset("rl");
    @(negedge clk);
    reset = 1'b0; ld_valid = 1'b0;

    // Reset during RUN, with start held high (ignored while running).
    @(negedge clk);
    start = 1'b1; prog_len = '0; max_cycles = 16'd200;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("rr_rstn", core_reset_n, 1);
      chk("rr_cnt", cycle_count, j);
    end
    #2 reset = 1'b1;
    #1 chk_reset("rr");
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    prog[0] = 32'h00A0_0093;
    prog[1] = 32'h0050_0113;
    prog[2] = HALT;
    do_run(3, 100, 2, '0, lc);
    chk("restart_halted", halted, 1);
    chk("restart_cnt", cycle_count, 3);
`ifdef CORE_RUN_CTRL_HALT_PC_EN
    chk("restart_halt_pc", halt_pc, 8);
`endif

    // Zero budget: halt in first cycle wins, otherwise timeout at once.
    prog[0] = HALT;
    do_run(1, 0, 2, '0, lc);
    chk("z_halted", halted, 1);
    prog[0] = NOP;
    do_run(1, 0, 2, '0, lc);
    chk("z_timeout", timeout, 1);
    chk("z_cnt", cycle_count, 1);

    // Handshake stalls: ld_valid 1,0,0,1,1 for three words.
    prog[0] = 32'h0070_0213;
    prog[1] = NOP;
    prog[2] = HALT;
    do_run(3, 50, 1, 32'h0000_0019, lc);
    chk("stall_load_cyc", lc, 5);
    chk("stall_halted", halted, 1);

    // Empty program goes straight to RUN over the existing memory.
    do_run(0, 30, 2, '0, lc);
    chk("len0_load_cyc", lc, 0);

    // Oversized program: clamped to the memory depth.
    for (int i = 0; i < 128; i++) prog[i] = rand_word();
    do_run(DEPTH + 5, 40, 2, '0, lc);
    chk("long_load_cyc", lc, DEPTH);

    // Randomised runs.
    for (int r = 0; r < 30; r++) begin
      r_len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(60, 127))
                                          : int'($urandom_range(0, 12));
      r_max = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 60));
      for (int i = 0; i < 128; i++) prog[i] = rand_word();
      do_run(r_len, r_max, 0, '0, lc);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
